// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between IF fetch and MEM-stage
// load/store, sequencing each access through a req/gnt/done handshake.

module mux2_n #(
  parameter int N = 32
) (
  input  logic         sel,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  output logic [N-1:0] out_y
);
  assign out_y = sel ? in1 : in0;
endmodule

module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_req,
  input  logic [AW-1:0] dm_addr,
  input  logic          dm_we,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic          addr_sel,
  output logic          if_gnt,
  output logic          dm_gnt,
  output logic          if_done,
  output logic          dm_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          addr_sel_q, addr_sel_d;
  logic          if_gnt_q, if_gnt_d;
  logic          dm_gnt_q, dm_gnt_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          if_wins;

  // MEM stage wins contention unless IF has already lost MAX_WAIT arbitrations in a row.
  assign if_wins = if_req && (!dm_req || (wait_cnt_q >= MAX_CNT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      addr_sel_q <= addr_sel_d;
      if_gnt_q   <= if_gnt_d;
      dm_gnt_q   <= dm_gnt_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (if_wins) begin
          state_d    = BUSY_IF;
          wait_cnt_d = '0;
        end else if (dm_req) begin
          state_d = BUSY_DM;
          if (if_req && (wait_cnt_q < MAX_CNT)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the transition about to be taken.
  always_comb begin
    mem_req_d  = (state_d != IDLE);
    if_gnt_d   = (state_d == BUSY_IF);
    dm_gnt_d   = (state_d == BUSY_DM);
    if_done_d  = (state_q == BUSY_IF) && (state_d == IDLE);
    dm_done_d  = (state_q == BUSY_DM) && (state_d == IDLE);
    mem_we_d   = mem_we_q;
    addr_sel_d = addr_sel_q;
    if ((state_q == IDLE) && (state_d != IDLE)) begin
      addr_sel_d = (state_d == BUSY_DM);
      mem_we_d   = dm_we && (state_d == BUSY_DM);
    end else if (state_d == IDLE) begin
      mem_we_d = 1'b0;
    end
  end

  mux2_n #(.N(AW)) u_addr_mux (
    .sel   (addr_sel_q),
    .in0   (if_addr),
    .in1   (dm_addr),
    .out_y (mem_addr)
  );

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign addr_sel = addr_sel_q;
  assign if_gnt   = if_gnt_q;
  assign dm_gnt   = dm_gnt_q;
  assign if_done  = if_done_q;
  assign dm_done  = dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every
// falling edge, plus directed scenarios with literal expectations.

module tb_mem_port_arbiter;

  localparam int AW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int CW       = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          dm_req = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic          dm_we = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, addr_sel, if_gnt, dm_gnt, if_done, dm_done;
  logic [AW-1:0] mem_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .dm_req   (dm_req),
    .dm_addr  (dm_addr),
    .dm_we    (dm_we),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .addr_sel (addr_sel),
    .if_gnt   (if_gnt),
    .dm_gnt   (dm_gnt),
    .if_done  (if_done),
    .dm_done  (dm_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: who owns the port, how many arbitrations IF has lost, and pending done pulses.
  int m_owner   = 0;   // 0 = nobody, 1 = IF, 2 = MEM stage
  int m_losses  = 0;
  bit m_sel     = 1'b0;
  bit m_we      = 1'b0;
  bit m_if_done = 1'b0;
  bit m_dm_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_losses = 0; m_sel = 1'b0; m_we = 1'b0;
      m_if_done = 1'b0; m_dm_done = 1'b0;
    end else begin
      m_if_done = 1'b0;
      m_dm_done = 1'b0;
      if (m_owner != 0) begin
        if (mem_ack) begin
          if (m_owner == 1) m_if_done = 1'b1;
          else              m_dm_done = 1'b1;
          m_owner = 0;
          m_we    = 1'b0;
        end
      end else if (if_req || dm_req) begin
        if (if_req && (!dm_req || m_losses >= MAX_WAIT)) begin
          m_owner  = 1;
          m_losses = 0;
          m_sel    = 1'b0;
          m_we     = 1'b0;
        end else begin
          m_owner = 2;
          m_sel   = 1'b1;
          m_we    = dm_we;
          if (if_req) m_losses = (m_losses + 1 > MAX_WAIT) ? MAX_WAIT : m_losses + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] exp_outs;
    exp_outs = {m_owner != 0, m_we, m_sel, m_owner == 1, m_owner == 2, m_if_done, m_dm_done};
    check("model_outs", {mem_req, mem_we, addr_sel, if_gnt, dm_gnt, if_done, dm_done}, exp_outs);
    check("model_addr", mem_addr, m_sel ? dm_addr : if_addr);
    check("gnt_excl", if_gnt & dm_gnt, 0);
    check("done_excl", if_done & dm_done, 0);
    check("req_is_gnt", mem_req ^ (if_gnt | dm_gnt), 0);
    check("addr_mux", mem_addr, addr_sel ? dm_addr : if_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;

    // Reset state
    if_addr = 32'h00400000;
    dm_addr = 32'h10010004;
    repeat (3) tick();
    check("rst_outs", {mem_req, mem_we, addr_sel, if_gnt, dm_gnt, if_done, dm_done}, 7'b0);
    check("rst_addr", mem_addr, 32'h00400000);
    rst_n = 1'b1;
    tick();

    // T1: single IF fetch, ack two cycles after the grant
    if_req = 1'b1;
    tick();
    check("t1_gnt_c1", {if_gnt, mem_req, addr_sel}, 3'b110);
    check("t1_addr", mem_addr, 32'h00400000);
    tick();
    check("t1_gnt_c2", {if_gnt, mem_req}, 2'b11);
    tick();
    check("t1_gnt_c3", {if_gnt, mem_req, if_done}, 3'b110);
    mem_ack = 1'b1;
    tick();
    check("t1_done", {if_gnt, mem_req, if_done}, 3'b001);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
    check("t1_done_gone", {if_gnt, if_done}, 2'b00);

    // T2: single store
    dm_req = 1'b1;
    dm_we  = 1'b1;
    tick();
    check("t2_gnt", {dm_gnt, mem_req, addr_sel, mem_we}, 4'b1111);
    check("t2_addr", mem_addr, 32'h10010004);
    mem_ack = 1'b1;
    tick();
    check("t2_done", {dm_gnt, dm_done, mem_we}, 3'b010);
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    mem_ack = 1'b0;
    tick();
    check("t2_after", {dm_done, mem_we, addr_sel}, 3'b001);

    // T3: contention with ack always high; every fifth grant goes to IF
    if_req  = 1'b1;
    dm_req  = 1'b1;
    mem_ack = 1'b1;
    ng = 0;
    for (int t = 0; t < 40 && ng < 10; t++) begin
      tick();
      if (if_gnt || dm_gnt) begin
        check($sformatf("t3_grant%0d", ng), {if_gnt, dm_gnt},
              (ng % 5 == 4) ? 2'b10 : 2'b01);
        ng++;
      end
    end
    check("t3_grant_count", ng, 10);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();

    // T4: stray ack in IDLE, then request dropped mid-access
    mem_ack = 1'b1;
    tick();
    check("t4_stray", {mem_req, if_done, dm_done}, 3'b000);
    mem_ack = 1'b0;
    tick();
    check("t4_stray_after", {mem_req, if_done, dm_done}, 3'b000);
    dm_req = 1'b1;
    tick();
    check("t4_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    tick();
    check("t4_held", {dm_gnt, dm_done}, 2'b10);
    mem_ack = 1'b1;
    tick();
    check("t4_done", {dm_gnt, dm_done}, 2'b01);
    mem_ack = 1'b0;
    tick();

    // T5: reset mid-access
    if_req = 1'b1;
    tick();
    check("t5_gnt", if_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async", {mem_req, if_gnt, addr_sel}, 3'b000);
    tick();
    check("t5_no_done", if_done, 1'b0);
    rst_n = 1'b1;
    tick();
    check("t5_regrant", {if_gnt, mem_req}, 2'b11);
    mem_ack = 1'b1;
    tick();
    check("t5_done", if_done, 1'b1);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();

    // T6: random traffic, checked every cycle by the model compare process
    for (int i = 0; i < 2000; i++) begin
      if_req  = 1'($urandom_range(0, 1));
      dm_req  = 1'($urandom_range(0, 1));
      dm_we   = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      if_addr = $urandom;
      dm_addr = $urandom;
      tick();
    end
    if_req  = 1'b0;
    dm_req  = 1'b0;
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    tick();
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
